mem_stage: RTL and testbench
============================

# mem_stage

Fourth stage of the five-stage MIPS pipeline on the SRAM-interface CPU. Sits between the execute stage and `wb_stage`: it captures the execute-stage bus, takes the synchronous data-SRAM read data, aligns and extends load results, and propagates exception/CP0 fields unchanged. It also drives the bypass/stall bus back to decode and the store-cancel signal back to execute, and it drops its instruction on a write-back exception flush.

## Interface
Parameters: none. Widths come from `mycpu.h`: `ES_TO_MS_BUS_WD`=163, `MS_TO_WS_BUS_WD`=122, `MS_TO_DS_BUS_WD`=39.

Ports:
- `clk` in 1: sole clock; all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `es_to_ms_valid` in 1: execute stage holds a valid instruction.
- `es_to_ms_bus` in 163: [162:156] load op one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}; [155:154] address low bits; [153:122] old rt value; [121:0] same layout as `ms_to_ws_bus`.
- `ms_allowin` out 1: this stage accepts a new instruction this cycle.
- `ws_allowin` in 1: write-back accepts.
- `ms_to_ws_valid` out 1: valid toward write-back.
- `ms_to_ws_bus` out 122: 121 exc_of, 120:89 badvaddr, 88 ades, 87 adel_if, 86 adel_ld, 85 ri, 84 bp, 83 flush, 82 bd, 81 eret, 80 sysc, 79 mfc0, 78 mtc0, 77:75 sel, 74:70 rd, 69 gpr_we, 68:64 dest, 63:32 result, 31:0 pc.
- `data_sram_rdata` in 32: read data for the request issued by execute the cycle before the instruction entered this stage.
- `exc_flush` in 1: write-back exception/eret flush.
- `ms_to_ds_bus` out 39: {fwd_we[38], fwd_block[37], dest[36:32], fwd_data[31:0]}.
- `ms_ex_to_es` out 1: the instruction in this stage is excepting or is eret; execute must suppress its store.

## Operation
- Control: `ms_valid` flag plus bus register `es_bus_r`.
	- `ms_ready_go`=1.
	- `ms_allowin` = !ms_valid || (ms_ready_go && ws_allowin).
	- `ms_to_ws_valid` = ms_valid && ms_ready_go && !exc_flush.
- Capture:
	- When `ms_allowin`: ms_valid <= es_to_ms_valid && !exc_flush.
	- When es_to_ms_valid && ms_allowin: es_bus_r <= es_to_ms_bus.
	- When exc_flush: ms_valid <= 0, regardless of allowin.
- Read-data hold:
	- `first` flag is set on capture and cleared after one cycle.
	- If `first` && !(ws_allowin), latch data_sram_rdata into `rdata_buf` and set `buf_v`.
	- Effective data = buf_v ? rdata_buf : data_sram_rdata.
	- `buf_v` clears when the instruction leaves or is flushed.
- Load extraction (byte/half selected by addr_lo):
	- lb: sign-extend the byte. lbu: zero-extend the byte.
	- lh: sign-extend the half at addr_lo[1]. lhu: zero-extend that half.
	- lw: the word.
	- lwl/lwr: merge with old rt per the MIPS32 big-endian-view rules on little-endian memory. Example: lwl addr_lo=1 gives {mem[15:0], rt[15:0]}; lwr addr_lo=2 gives {rt[31:16], mem[31:16]}.
	- Non-load: pass result [63:32] unchanged.
- Exceptions: the 122-bit field is forwarded verbatim except result.
	- adel_ld set suppresses the load merge (result=badvaddr path, gpr_we forced 0).
	- bit 83 (flush) output = stored flush bit.
- Forwarding:
	- fwd_we = ms_valid && gpr_we && !any_exc.
	- fwd_block = ms_valid && (mfc0 || (load && !buf_v && 0)). Decode stalls on mfc0 only, because load data is available this cycle.
	- fwd_data = final result.
- `ms_ex_to_es` = ms_valid && (any exception bit || eret).

## Timing
- Reset (async, while resetn=0): ms_valid=0, first=0, buf_v=0, es_bus_r=0, rdata_buf=0.
	- Consequently ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_bus=0, ms_ex_to_es=0.
- Latency: one cycle per instruction when ws_allowin=1.
- Stall: a stall of N cycles holds the bus stable, and load data stays correct via `rdata_buf`.
- exc_flush and a new capture in the same cycle: the flush wins; ms_valid=0 next cycle.
- Reset deassertion mid-operation: the pipeline restarts empty; no residual buf_v.

## Configuration
- `MEM_UNALIGNED_LOAD_EN`
	- Defined: lwl/lwr merge logic present.
	- Undefined: lwl/lwr bits ignored; result for them equals the lw result. Bench skips lwl/lwr cases.

## Structure
- In `mycpu.h`: bus widths and the load-op bit indices (`LD_LB`..`LD_LWR`).
- One natural sub-module: `mem_load_align` (combinational: op, addr_lo, rdata, rt → result).

## Test plan
- lb from 0x...01, rdata=0x1234_80FF → result 0xFFFF_FF80; lbu → 0x0000_0080.
- lh addr_lo=2, rdata=0x8001_7FFF → 0xFFFF_8001; lw → 0x8001_7FFF.
- lwl addr_lo=1, rt=0xAABB_CCDD, rdata=0x1122_3344 → 0x3344_CCDD; lwr addr_lo=2 → 0xAABB_1122.
- Load then ws_allowin=0 for 3 cycles with rdata changing to 0xDEAD_BEEF → delivered result still from the original 0x1122_3344.
- exc_flush asserted in the cycle an instruction is captured → ms_to_ws_valid=0 next cycle, fwd_we=0.
- Instruction with adel_ld=1 → ms_ex_to_es=1, gpr_we output 0, badvaddr passed through; resetn pulsed low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths, load-op indices and bus layouts for the memory stage (MEM_UNALIGNED_LOAD_EN)
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 163;
   localparam int MS_TO_WS_BUS_WD = 122;
   localparam int MS_TO_DS_BUS_WD = 39;

   localparam int LD_OP_WD = 7;
   localparam int LD_LB    = 6;
   localparam int LD_LBU   = 5;
   localparam int LD_LH    = 4;
   localparam int LD_LHU   = 3;
   localparam int LD_LW    = 2;
   localparam int LD_LWL   = 1;
   localparam int LD_LWR   = 0;

   typedef struct packed {
      logic        exc_of;
      logic [31:0] badvaddr;
      logic        ades;
      logic        adel_if;
      logic        adel_ld;
      logic        ri;
      logic        bp;
      logic        flush;
      logic        bd;
      logic        eret;
      logic        sysc;
      logic        mfc0;
      logic        mtc0;
      logic [2:0]  sel;
      logic [4:0]  rd;
      logic        gpr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } ms_ws_bus_t;

   typedef struct packed {
      logic [LD_OP_WD-1:0] ld_op;
      logic [1:0]          addr_lo;
      logic [31:0]         rt;
      ms_ws_bus_t          ws;
   } es_ms_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load byte/half/word extraction and lwl/lwr merge (lwl/lwr only with MEM_UNALIGNED_LOAD_EN)
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [LD_OP_WD-1:0] ld_op,
   input  logic [1:0]          addr_lo,
   input  logic [31:0]         rdata,
   input  logic [31:0]         rt,
   input  logic [31:0]         alu_result,
   output logic [31:0]         result
);
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = rdata[7:0];
      case (addr_lo)
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         2'd3:    ld_byte = rdata[31:24];
         default: ld_byte = rdata[7:0];
      endcase
   end

   assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = alu_result;
      if (ld_op[LD_LB])       result = {{24{ld_byte[7]}}, ld_byte};
      else if (ld_op[LD_LBU]) result = {24'd0, ld_byte};
      else if (ld_op[LD_LH])  result = {{16{ld_half[15]}}, ld_half};
      else if (ld_op[LD_LHU]) result = {16'd0, ld_half};
`ifdef MEM_UNALIGNED_LOAD_EN
      else if (ld_op[LD_LW])  result = rdata;
      // Memory is little-endian; lwl/lwr keep the big-endian-view byte merge
      else if (ld_op[LD_LWL]) begin
         case (addr_lo)
            2'd0:    result = {rdata[7:0],  rt[23:0]};
            2'd1:    result = {rdata[15:0], rt[15:0]};
            2'd2:    result = {rdata[23:0], rt[7:0]};
            default: result = rdata;
         endcase
      end
      else if (ld_op[LD_LWR]) begin
         case (addr_lo)
            2'd0:    result = rdata;
            2'd1:    result = {rt[31:24], rdata[31:8]};
            2'd2:    result = {rt[31:16], rdata[31:16]};
            default: result = {rt[31:8],  rdata[31:24]};
         endcase
      end
`else
      else if (ld_op[LD_LW] || ld_op[LD_LWL] || ld_op[LD_LWR]) result = rdata;
`endif
   end

`ifndef MEM_UNALIGNED_LOAD_EN
   logic unused_rt;
   assign unused_rt = ^rt;
`endif

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS pipeline memory stage: capture, load-data hold, alignment, bypass (MEM_UNALIGNED_LOAD_EN)
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_allowin,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic [31:0]                data_sram_rdata,
   input  logic                       exc_flush,
   output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
   output logic                       ms_ex_to_es
);
   logic        ms_valid;
   logic        first;
   logic        buf_v;
   es_ms_bus_t  es_bus_r;
   logic [31:0] rdata_buf;
   logic [31:0] eff_rdata;
   logic [31:0] ld_result;
   ms_ws_bus_t  ws_out;
   logic        ms_ready_go;
   logic        any_exc;
   logic        fwd_we;
   logic        fwd_block;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go && !exc_flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid  <= 1'b0;
         first     <= 1'b0;
         buf_v     <= 1'b0;
         es_bus_r  <= '0;
         rdata_buf <= 32'd0;
      end else begin
         if (exc_flush)
            ms_valid <= 1'b0;
         else if (ms_allowin)
            ms_valid <= es_to_ms_valid;
         if (es_to_ms_valid && ms_allowin)
            es_bus_r <= es_ms_bus_t'(es_to_ms_bus);
         first <= es_to_ms_valid && ms_allowin && !exc_flush;
         // SRAM data is only valid in the first cycle; keep it if write-back stalls
         if (exc_flush)
            buf_v <= 1'b0;
         else if (first && !ws_allowin) begin
            buf_v     <= 1'b1;
            rdata_buf <= data_sram_rdata;
         end else if (ms_valid && ws_allowin)
            buf_v <= 1'b0;
      end
   end

   assign eff_rdata = buf_v ? rdata_buf : data_sram_rdata;

   mem_load_align u_align (
      .ld_op      (es_bus_r.ld_op),
      .addr_lo    (es_bus_r.addr_lo),
      .rdata      (eff_rdata),
      .rt         (es_bus_r.rt),
      .alu_result (es_bus_r.ws.result),
      .result     (ld_result)
   );

   assign any_exc = es_bus_r.ws.exc_of | es_bus_r.ws.ades | es_bus_r.ws.adel_if |
                    es_bus_r.ws.adel_ld | es_bus_r.ws.ri | es_bus_r.ws.bp | es_bus_r.ws.sysc;

   always_comb begin
      ws_out = es_bus_r.ws;
      if (es_bus_r.ws.adel_ld) begin
         ws_out.result = es_bus_r.ws.badvaddr;
         ws_out.gpr_we = 1'b0;
      end else begin
         ws_out.result = ld_result;
      end
   end

   assign ms_to_ws_bus = ws_out;

   // Load data arrives this cycle, so only mfc0 needs decode to wait
   assign fwd_we       = ms_valid && es_bus_r.ws.gpr_we && !any_exc;
   assign fwd_block    = ms_valid && es_bus_r.ws.mfc0;
   assign ms_to_ds_bus = {fwd_we, fwd_block, ws_out.dest, ws_out.result};
   assign ms_ex_to_es  = ms_valid && (any_exc || es_bus_r.ws.eret);

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage (lwl/lwr cases with MEM_UNALIGNED_LOAD_EN)
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic         clk = 1'b0;
   logic         resetn;
   logic         es_to_ms_valid;
   logic [162:0] es_to_ms_bus;
   logic         ms_allowin;
   logic         ws_allowin;
   logic         ms_to_ws_valid;
   logic [121:0] ms_to_ws_bus;
   logic [31:0]  data_sram_rdata;
   logic         exc_flush;
   logic [38:0]  ms_to_ds_bus;
   logic         ms_ex_to_es;

   ms_ws_bus_t sb_q[$];
   int n_cmp = 0;
   int n_mis = 0;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .ms_allowin      (ms_allowin),
      .ws_allowin      (ws_allowin),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .data_sram_rdata (data_sram_rdata),
      .exc_flush       (exc_flush),
      .ms_to_ds_bus    (ms_to_ds_bus),
      .ms_ex_to_es     (ms_ex_to_es)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      ms_ws_bus_t e;
      if (resetn && ms_to_ws_valid && ws_allowin) begin
         if (sb_q.size() == 0)
            check("unexpected_out", 128'(ms_to_ws_valid), 128'(0));
         else begin
            e = sb_q.pop_front();
            check("ws_bus", 128'(ms_to_ws_bus), 128'(e));
         end
      end
   end

   function automatic es_ms_bus_t mk(input int op, input logic [1:0] lo, input logic [31:0] rt,
                                     input logic [31:0] res, input logic [4:0] dest);
      es_ms_bus_t b;
      b = '0;
      if (op >= 0) b.ld_op[op] = 1'b1;
      b.addr_lo   = lo;
      b.rt        = rt;
      b.ws.result = res;
      b.ws.gpr_we = 1'b1;
      b.ws.dest   = dest;
      b.ws.sel    = 3'd2;
      b.ws.rd     = 5'd7;
      b.ws.pc     = 32'hBFC0_0100 + 32'(dest) * 4;
      return b;
   endfunction

   // Drives one instruction; next call follows back-to-back
   task automatic send(input string tag, input es_ms_bus_t b, input logic [31:0] rdata,
                       input ms_ws_bus_t e, input logic fwe, input logic fblk, input logic ex);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = b;
      @(posedge clk);
      #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = rdata;
      sb_q.push_back(e);
      @(negedge clk);
      check({tag, "_ds"}, 128'(ms_to_ds_bus), 128'({fwe, fblk, b.ws.dest, e.result}));
      check({tag, "_ex"}, 128'(ms_ex_to_es), 128'(ex));
   endtask

   task automatic load(input string tag, input int op, input logic [1:0] lo, input logic [31:0] rt,
                       input logic [31:0] rdata, input logic [31:0] exp_res);
      es_ms_bus_t b;
      ms_ws_bus_t e;
      b = mk(op, lo, rt, 32'h0000_0040, 5'd3 + 5'(op));
      e = b.ws;
      e.result = exp_res;
      send(tag, b, rdata, e, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      es_ms_bus_t b;
      ms_ws_bus_t e;
      resetn = 1'b0;
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      ws_allowin = 1'b1;
      data_sram_rdata = 32'd0;
      exc_flush = 1'b0;
      #1;
      check("rst_allowin", 128'(ms_allowin), 128'(1));
      check("rst_valid", 128'(ms_to_ws_valid), 128'(0));
      check("rst_ds", 128'(ms_to_ds_bus), 128'(0));
      check("rst_ex", 128'(ms_ex_to_es), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      load("lb",  LD_LB,  2'd1, 32'h0, 32'h1234_80FF, 32'hFFFF_FF80);
      load("lbu", LD_LBU, 2'd1, 32'h0, 32'h1234_80FF, 32'h0000_0080);
      load("lh",  LD_LH,  2'd2, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
      load("lhu", LD_LHU, 2'd0, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF);
      load("lw",  LD_LW,  2'd0, 32'h0, 32'h8001_7FFF, 32'h8001_7FFF);
`ifdef MEM_UNALIGNED_LOAD_EN
      load("lwl", LD_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
      load("lwr", LD_LWR, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);
`endif

      // non-load with mfc0 passes result and blocks decode
      b = mk(-1, 2'd3, 32'h0, 32'hCAFE_BABE, 5'd20);
      b.ws.mfc0 = 1'b1;
      send("mfc0", b, 32'h1111_1111, b.ws, 1'b1, 1'b1, 1'b0);

      // eret: no register write, store cancel raised
      b = mk(-1, 2'd0, 32'h0, 32'h0, 5'd0);
      b.ws.gpr_we = 1'b0;
      b.ws.eret = 1'b1;
      b.ws.flush = 1'b1;
      send("eret", b, 32'h0, b.ws, 1'b0, 1'b0, 1'b1);

      // adel_ld: result carries badvaddr, gpr_we dropped
      b = mk(LD_LW, 2'd3, 32'h0, 32'h1000_0003, 5'd9);
      b.ws.adel_ld = 1'b1;
      b.ws.badvaddr = 32'h1000_0003;
      e = b.ws;
      e.result = 32'h1000_0003;
      e.gpr_we = 1'b0;
      send("adel", b, 32'h5A5A_5A5A, e, 1'b0, 1'b0, 1'b1);
      idle();

      // stall for 3 cycles while SRAM data changes
      ws_allowin = 1'b0;
      load("stall_lw", LD_LW, 2'd0, 32'h0, 32'h1122_3344, 32'h1122_3344);
      @(posedge clk);
      #1;
      data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stall_allowin", 128'(ms_allowin), 128'(0));
      check("stall_fwd_data", 128'(ms_to_ds_bus[31:0]), 128'(32'h1122_3344));
      repeat (2) @(posedge clk);
      #1;
      ws_allowin = 1'b1;
      idle();
      check("stall_drained", 128'(sb_q.size()), 128'(0));

      // flush in the capture cycle wins
      b = mk(LD_LW, 2'd0, 32'h0, 32'h0, 5'd11);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = b;
      exc_flush = 1'b1;
      @(posedge clk);
      #1;
      es_to_ms_valid = 1'b0;
      exc_flush = 1'b0;
      @(negedge clk);
      check("flush_valid", 128'(ms_to_ws_valid), 128'(0));
      check("flush_fwd_we", 128'(ms_to_ds_bus[38]), 128'(0));
      idle();

      // reset pulse in the middle of a stall
      ws_allowin = 1'b0;
      load("rst_lw", LD_LW, 2'd0, 32'h0, 32'h7777_0000, 32'h7777_0000);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      sb_q.delete();
      #1;
      check("mid_rst_valid", 128'(ms_to_ws_valid), 128'(0));
      check("mid_rst_ds", 128'(ms_to_ds_bus), 128'(0));
      check("mid_rst_ws_bus", 128'(ms_to_ws_bus), 128'(0));
      check("mid_rst_allowin", 128'(ms_allowin), 128'(1));
      @(negedge clk);
      resetn = 1'b1;
      ws_allowin = 1'b1;
      load("post_rst_lw", LD_LW, 2'd0, 32'h0, 32'h5555_AAAA, 32'h5555_AAAA);
      idle();
      idle();

      check("sb_empty", 128'(sb_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
